// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a 4-bit ALU: grant in IDLE, compute in EXEC,
// hold the registered result in RESP until the consumer takes it.
module alu_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic [3:0] a0,
    input  logic [3:0] a1,
    input  logic [3:0] b0,
    input  logic [3:0] b1,
    input  logic [3:0] op0,
    input  logic [3:0] op1,
    input  logic       rsp_ready,
    output logic       gnt0,
    output logic       gnt1,
    output logic [3:0] y,
    output logic       y_valid,
    output logic       y_id,
    output logic       dz
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t     state_reg, state_next;
    logic       rr_reg;
    logic [3:0] a_reg, b_reg, op_reg;
    logic       id_reg;
    logic [3:0] y_reg;
    logic       y_id_reg, dz_reg;

    logic       grant_any;
    logic       win;
    logic [1:0] gnt_vec;
    logic [3:0] alu_y;
    logic       alu_dz;

    // Port 1 wins when it is alone, or on a tie when round-robin points at it.
    assign win       = req1 && (!req0 || (RR_EN && rr_reg));
    assign grant_any = (state_reg == IDLE) && !rst && (req0 || req1);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_gnt
            assign gnt_vec[gi] = grant_any && (win == gi[0]);
        end
    endgenerate

    assign gnt0    = gnt_vec[0];
    assign gnt1    = gnt_vec[1];
    assign y       = y_reg;
    assign y_id    = y_id_reg;
    assign dz      = dz_reg;
    assign y_valid = (state_reg == RESP);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant_any) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        alu_y  = 4'h0;
        alu_dz = 1'b0;
        case (op_reg)
            4'h0: alu_y = a_reg + b_reg;
            4'h1: alu_y = a_reg - b_reg;
            4'h2: alu_y = a_reg * b_reg;
            4'h3: if (b_reg == 4'h0) alu_dz = 1'b1; else alu_y = a_reg / b_reg;
            4'h4: if (b_reg == 4'h0) alu_dz = 1'b1; else alu_y = a_reg % b_reg;
            4'h5: alu_y = a_reg & b_reg;
            4'h6: alu_y = a_reg | b_reg;
            4'h7: alu_y = a_reg ^ b_reg;
            4'h8: alu_y = ~a_reg;
            4'h9: alu_y = ~b_reg;
            4'hA: alu_y = ~(a_reg ^ b_reg);
            4'hB: alu_y = {3'b000, (a_reg != 4'h0) && (b_reg != 4'h0)};
            4'hC: alu_y = {3'b000, (a_reg != 4'h0) || (b_reg != 4'h0)};
            4'hD: alu_y = {3'b000, a_reg == b_reg};
            4'hE: alu_y = {3'b000, a_reg != b_reg};
            default: alu_y = 4'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            rr_reg    <= 1'b0;
            a_reg     <= 4'h0;
            b_reg     <= 4'h0;
            op_reg    <= 4'h0;
            id_reg    <= 1'b0;
            y_reg     <= 4'h0;
            y_id_reg  <= 1'b0;
            dz_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (grant_any) begin
                a_reg  <= win ? a1 : a0;
                b_reg  <= win ? b1 : b0;
                op_reg <= win ? op1 : op0;
                id_reg <= win;
                rr_reg <= ~win;
            end
            if (state_reg == EXEC) begin
                y_reg    <= alu_y;
                dz_reg   <= alu_dz;
                y_id_reg <= id_reg;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a round-robin and a fixed-priority instance share
// stimulus and are checked every cycle against a transaction-level model.
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0, rsp_ready = 1'b0;
    logic [3:0] a0 = 4'h0, a1 = 4'h0, b0 = 4'h0, b1 = 4'h0, op0 = 4'h0, op1 = 4'h0;

    logic [1:0] g0_o, g1_o, yv_o, yid_o, dz_o;
    logic [3:0] y_o [2];

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    always #5 clk = ~clk;

    alu_arbiter #(.RR_EN(1'b1)) dut_rr (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .a0(a0), .a1(a1), .b0(b0), .b1(b1), .op0(op0), .op1(op1),
        .rsp_ready(rsp_ready), .gnt0(g0_o[0]), .gnt1(g1_o[0]),
        .y(y_o[0]), .y_valid(yv_o[0]), .y_id(yid_o[0]), .dz(dz_o[0])
    );

    alu_arbiter #(.RR_EN(1'b0)) dut_fp (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .a0(a0), .a1(a1), .b0(b0), .b1(b1), .op0(op0), .op1(op1),
        .rsp_ready(rsp_ready), .gnt0(g0_o[1]), .gnt1(g1_o[1]),
        .y(y_o[1]), .y_valid(yv_o[1]), .y_id(yid_o[1]), .dz(dz_o[1])
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: index 0 is round-robin, index 1 is fixed priority.
    int m_rr [2], m_busy [2], m_valid [2], m_y [2], m_dz [2], m_id [2];
    int m_a [2], m_b [2], m_op [2];

    function automatic void model_alu(input int op, input int a, input int b,
                                      output int r, output int z);
        z = 0;
        case (op)
            0:  r = (a + b) % 16;
            1:  r = (a - b + 16) % 16;
            2:  r = (a * b) % 16;
            3:  if (b == 0) begin r = 0; z = 1; end else r = a / b;
            4:  if (b == 0) begin r = 0; z = 1; end else r = a % b;
            5:  r = a & b;
            6:  r = a | b;
            7:  r = a ^ b;
            8:  r = 15 - a;
            9:  r = 15 - b;
            10: r = 15 - (a ^ b);
            11: r = (a != 0 && b != 0) ? 1 : 0;
            12: r = (a != 0 || b != 0) ? 1 : 0;
            13: r = (a == b) ? 1 : 0;
            14: r = (a != b) ? 1 : 0;
            default: r = 0;
        endcase
    endfunction

    function automatic int exp_any(input int k);
        return (!rst && m_busy[k] == 0 && (req0 || req1)) ? 1 : 0;
    endfunction

    function automatic int exp_win(input int k);
        if (req0 && req1) return (k == 0) ? m_rr[k] : 0;
        return req1 ? 1 : 0;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_rr[k] = 0; m_busy[k] = 0; m_valid[k] = 0;
                m_y[k] = 0; m_dz[k] = 0; m_id[k] = 0;
            end else if (m_busy[k] == 0) begin
                if (exp_any(k) != 0) begin
                    int w;
                    w = exp_win(k);
                    m_a[k]  = (w == 1) ? int'(a1) : int'(a0);
                    m_b[k]  = (w == 1) ? int'(b1) : int'(b0);
                    m_op[k] = (w == 1) ? int'(op1) : int'(op0);
                    m_id[k] = w;
                    m_rr[k] = 1 - w;
                    m_busy[k] = 1;
                end
            end else if (m_valid[k] != 0) begin
                if (rsp_ready) begin
                    m_valid[k] = 0;
                    m_busy[k]  = 0;
                end
            end else begin
                model_alu(m_op[k], m_a[k], m_b[k], m_y[k], m_dz[k]);
                m_valid[k] = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int k = 0; k < 2; k++) begin
                int e_any, e_w;
                e_any = exp_any(k);
                e_w   = exp_win(k);
                chk($sformatf("dut%0d_gnt0", k), int'(g0_o[k]), (e_any != 0 && e_w == 0) ? 1 : 0);
                chk($sformatf("dut%0d_gnt1", k), int'(g1_o[k]), (e_any != 0 && e_w == 1) ? 1 : 0);
                chk($sformatf("dut%0d_y_valid", k), int'(yv_o[k]), m_valid[k]);
                if (m_valid[k] != 0) begin
                    chk($sformatf("dut%0d_y", k), int'(y_o[k]), m_y[k]);
                    chk($sformatf("dut%0d_y_id", k), int'(yid_o[k]), m_id[k]);
                    chk($sformatf("dut%0d_dz", k), int'(dz_o[k]), m_dz[k]);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic set_port(input int p, input int a, input int b, input int op);
        if (p == 0) begin
            req0 = 1'b1; a0 = 4'(a); b0 = 4'(b); op0 = 4'(op);
        end else begin
            req1 = 1'b1; a1 = 4'(a); b1 = 4'(b); op1 = 4'(op);
        end
    endtask

    // One request through dut_rr with rsp_ready held high; returns the result.
    task automatic do_op(input int p, input int a, input int b, input int op,
                         output int ry, output int rdz, output int rid);
        bit got;
        int lat;
        ry = -1; rdz = -1; rid = -1;
        set_port(p, a, b, op);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            #1;
            if (g0_o[0] || g1_o[0]) got = 1'b1;
            else cyc();
        end
        if (!got) chk("gnt_timeout", 0, 1);
        cyc();
        req0 = 1'b0; req1 = 1'b0;
        got = 1'b0;
        lat = 1;
        for (int i = 0; i < 10 && !got; i++) begin
            #1;
            if (yv_o[0]) begin
                got = 1'b1;
                ry = int'(y_o[0]); rdz = int'(dz_o[0]); rid = int'(yid_o[0]);
            end else begin
                cyc();
                lat++;
            end
        end
        chk("latency", lat, 2);
        cyc();
    endtask

    int vec_op [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
    int vec_a  [16] = '{15, 0, 7, 13, 13, 12, 12, 12, 12, 12, 12, 3, 3, 5, 5, 9};
    int vec_b  [16] = '{1, 1, 3, 4, 4, 10, 10, 10, 10, 10, 10, 0, 0, 5, 5, 9};
    int vec_y  [16] = '{0, 15, 5, 3, 1, 8, 14, 6, 3, 5, 9, 0, 1, 1, 0, 0};

    initial begin
        int ry, rdz, rid;
        int seq_rr [$];
        int fp0, fp1;

        rsp_ready = 1'b0;
        rst = 1'b1;
        cyc();
        cmp_en = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chk("reset_y_valid", int'(yv_o[0]), 0);
        chk("reset_y", int'(y_o[0]), 0);

        // Single request, then backpressure with a pending request on port 1.
        set_port(0, 3, 5, 0);
        #1;
        chk("single_gnt0", int'(g0_o[0]), 1);
        cyc();
        req0 = 1'b0;
        #1;
        chk("single_n1_valid", int'(yv_o[0]), 0);
        cyc();
        #1;
        chk("single_valid", int'(yv_o[0]), 1);
        chk("single_y", int'(y_o[0]), 8);
        chk("single_id", int'(yid_o[0]), 0);
        chk("single_dz", int'(dz_o[0]), 0);
        set_port(1, 7, 2, 1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            #1;
            chk("bp_no_gnt", int'(g1_o[0]), 0);
            chk("bp_y_hold", int'(y_o[0]), 8);
        end
        rsp_ready = 1'b1;
        cyc();
        #1;
        chk("bp_release_gnt1", int'(g1_o[0]), 1);
        cyc();
        req1 = 1'b0;
        cyc();
        #1;
        chk("bp_pending_y", int'(y_o[0]), 5);
        chk("bp_pending_id", int'(yid_o[0]), 1);
        cyc();

        // Divide and modulo, including divide by zero.
        do_op(0, 9, 0, 3, ry, rdz, rid);
        chk("div0_y", ry, 0);
        chk("div0_dz", rdz, 1);
        do_op(1, 9, 4, 4, ry, rdz, rid);
        chk("mod_y", ry, 1);
        chk("mod_dz", rdz, 0);
        chk("mod_id", rid, 1);

        for (int i = 0; i < 16; i++) begin
            do_op(i % 2, vec_a[i], vec_b[i], vec_op[i], ry, rdz, rid);
            chk($sformatf("op%0d_y", vec_op[i]), ry, vec_y[i]);
        end

        // Tie after reset: round-robin alternates starting at 0, fixed priority stays at 0.
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        set_port(0, 1, 1, 0);
        set_port(1, 5, 1, 1);
        fp0 = 0; fp1 = 0;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (g0_o[0]) seq_rr.push_back(0);
            if (g1_o[0]) seq_rr.push_back(1);
            if (g0_o[1]) fp0++;
            if (g1_o[1]) fp1++;
            cyc();
        end
        chk("tie_rr_count", seq_rr.size(), 4);
        for (int i = 0; i < seq_rr.size() && i < 4; i++)
            chk($sformatf("tie_rr_grant%0d", i), seq_rr[i], i % 2);
        chk("tie_fp_gnt0", fp0, 4);
        chk("tie_fp_gnt1", fp1, 0);

        // Reset during EXEC after a port-0 grant left rr pointing at port 1.
        req1 = 1'b0;
        #1;
        chk("rst_pre_gnt0", int'(g0_o[0]), 1);
        cyc();
        rst = 1'b1;
        req1 = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chk("rst_y_valid", int'(yv_o[0]), 0);
        chk("rst_y", int'(y_o[0]), 0);
        chk("rst_y_id", int'(yid_o[0]), 0);
        chk("rst_dz", int'(dz_o[0]), 0);
        chk("rst_tie_gnt0", int'(g0_o[0]), 1);
        chk("rst_tie_gnt1", int'(g1_o[0]), 0);
        cyc();
        req0 = 1'b0; req1 = 1'b0;
        for (int i = 0; i < 4; i++) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
